reg_de_elastic: RTL and testbench

//  Decode->Execute pipeline register with valid/ready handshake, stall back-pressure, sync flush and skid buffering.

---
 rtl/pipe_pkg.sv | 44 ++++
 rtl/reg_de_elastic_if.sv | 33 +++
 rtl/pipe_skid_buf.sv | 91 +++++++++
 rtl/reg_de_elastic.sv | 49 ++++
 tb/tb_reg_de_elastic.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the decode->execute pipeline register.
//   de_ctrl_t           : control bundle carried from decode to execute
//   de_state_e          : occupancy of the elastic stage (EMPTY / ONE / TWO)
//   DE_SIDE_EFFECT_MASK : control bits that must read 0 while ValidE=0
package pipe_pkg;

  localparam int DE_WA_W     = 4;
  localparam int DE_ALUCTL_W = 3;

  typedef struct packed {
    logic                   PCSrc;
    logic                   RegWrite;
    logic                   MemToReg;
    logic                   MemWrite;
    logic                   Branch;
    logic                   ALUSrc;
    logic                   FlagWrite;
    logic [DE_ALUCTL_W-1:0] ALUControl;
    logic [3:0]             Cond;
    logic [DE_WA_W-1:0]     WA3;
  } de_ctrl_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } de_state_e;

  // Fields that commit architectural state; forced low on a bubble so a stale
  // payload can never write the register file, memory, flags or PC.
  localparam de_ctrl_t DE_SIDE_EFFECT_MASK = '{
    PCSrc:      1'b1,
    RegWrite:   1'b1,
    MemToReg:   1'b0,
    MemWrite:   1'b1,
    Branch:     1'b1,
    ALUSrc:     1'b0,
    FlagWrite:  1'b1,
    ALUControl: '0,
    Cond:       '0,
    WA3:        '0
  };

endpackage

// File: rtl/reg_de_elastic_if.sv
// Decode->execute handshake/payload bundle.
//   slave  : the pipeline stage (takes decode side, drives execute side)
//   master : the environment (drives decode side and ReadyE)
interface reg_de_elastic_if import pipe_pkg::*; #(
  parameter int SIZE    = 32,
  parameter int FLAGS_W = 4
);
  logic               ValidD;
  logic               ReadyD;
  de_ctrl_t           CtrlD;
  logic [FLAGS_W-1:0] FlagsD;
  logic [SIZE-1:0]    RD1;
  logic [SIZE-1:0]    RD2;
  logic [SIZE-1:0]    ExtImmD;

  logic               ValidE;
  logic               ReadyE;
  de_ctrl_t           CtrlE;
  logic [FLAGS_W-1:0] FlagsE;
  logic [SIZE-1:0]    RE1;
  logic [SIZE-1:0]    RE2;
  logic [SIZE-1:0]    ExtImmE;

  modport slave (
    input  ValidD, CtrlD, FlagsD, RD1, RD2, ExtImmD, ReadyE,
    output ReadyD, ValidE, CtrlE, FlagsE, RE1, RE2, ExtImmE
  );

  modport master (
    output ValidD, CtrlD, FlagsD, RD1, RD2, ExtImmD, ReadyE,
    input  ReadyD, ValidE, CtrlE, FlagsE, RE1, RE2, ExtImmE
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic elastic register on a flattened payload.
//   SKID_EN=1: main + skid entry, in_ready is a pure register output.
//   SKID_EN=0: main entry only, in_ready = ~out_valid | out_ready.
// Ports: CLK, RST (async, active high), CLR (sync flush),
//        in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream).
//
// state | meaning
// EMPTY | nothing held
// ONE   | main entry valid
// TWO   | main and skid valid, upstream stalled (SKID_EN=1 only)
module pipe_skid_buf import pipe_pkg::*; #(
  parameter int W       = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CLR,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  de_state_e    state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         ready_q;
  logic         valid_q;
  logic         accept;
  logic         consume;

  assign in_ready  = SKID_EN ? ready_q : (~valid_q | out_ready);
  assign out_valid = valid_q;
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign consume   = valid_q & out_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else if (CLR) begin
      // Flush wins over both accept and consume; payload is left as don't-care.
      state   <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q  <= in_data;
            valid_q <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && !consume) begin
            // Only reachable with the skid entry present: without it, in_ready
            // in ONE already implies consume.
            skid_q  <= in_data;
            ready_q <= 1'b0;
            state   <= TWO;
          end else if (accept && consume) begin
            main_q  <= in_data;
          end else if (consume) begin
            valid_q <= 1'b0;
            state   <= EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            main_q  <= skid_q;
            ready_q <= 1'b1;
            state   <= ONE;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_de_elastic.sv
// Decode->execute pipeline register: valid/ready handshake, skid buffering,
// synchronous flush (CLR) and bubble gating of side-effect control bits.
// Ports: CLK, RST (async, active high), CLR (sync flush),
//        bus (reg_de_elastic_if.slave): ValidD/ReadyD/CtrlD/FlagsD/RD1/RD2/ExtImmD in,
//        ValidE/ReadyE/CtrlE/FlagsE/RE1/RE2/ExtImmE out.
module reg_de_elastic import pipe_pkg::*; #(
  parameter int SIZE     = 32,
  parameter int WA_W     = DE_WA_W,
  parameter int ALUCTL_W = DE_ALUCTL_W,
  parameter int FLAGS_W  = 4,
  parameter bit SKID_EN  = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  reg_de_elastic_if.slave  bus
);

  // Seven single-bit controls + ALUControl + 4-bit Cond + WA3.
  localparam int CTRL_W = 11 + ALUCTL_W + WA_W;
  localparam int PW     = CTRL_W + FLAGS_W + 3 * SIZE;

  logic [PW-1:0] pay_d;
  logic [PW-1:0] pay_e;
  de_ctrl_t      ctrl_e;
  logic          valid_e;

  assign pay_d = {bus.CtrlD, bus.FlagsD, bus.RD1, bus.RD2, bus.ExtImmD};

  pipe_skid_buf #(
    .W       (PW),
    .SKID_EN (SKID_EN)
  ) u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .CLR       (CLR),
    .in_valid  (bus.ValidD),
    .in_ready  (bus.ReadyD),
    .in_data   (pay_d),
    .out_valid (valid_e),
    .out_ready (bus.ReadyE),
    .out_data  (pay_e)
  );

  assign {ctrl_e, bus.FlagsE, bus.RE1, bus.RE2, bus.ExtImmE} = pay_e;
  assign bus.ValidE = valid_e;
  assign bus.CtrlE  = valid_e ? ctrl_e : de_ctrl_t'(ctrl_e & ~DE_SIDE_EFFECT_MASK);

endmodule

// File: tb/tb_reg_de_elastic.sv
module tb_reg_de_elastic;
  import pipe_pkg::*;

  localparam int SIZE    = 32;
  localparam int FLAGS_W = 4;
  localparam int CW      = $bits(de_ctrl_t);

  typedef struct packed {
    de_ctrl_t           ctrl;
    logic [FLAGS_W-1:0] flags;
    logic [SIZE-1:0]    rd1;
    logic [SIZE-1:0]    rd2;
    logic [SIZE-1:0]    imm;
  } op_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic CLR = 1'b0;

  always #5 CLK = ~CLK;

  reg_de_elastic_if #(.SIZE(SIZE), .FLAGS_W(FLAGS_W)) bus1 ();
  reg_de_elastic_if #(.SIZE(SIZE), .FLAGS_W(FLAGS_W)) bus0 ();

  reg_de_elastic #(.SIZE(SIZE), .FLAGS_W(FLAGS_W), .SKID_EN(1'b1)) u_dut_skid (
    .CLK (CLK), .RST (RST), .CLR (CLR), .bus (bus1)
  );

  reg_de_elastic #(.SIZE(SIZE), .FLAGS_W(FLAGS_W), .SKID_EN(1'b0)) u_dut_flat (
    .CLK (CLK), .RST (RST), .CLR (CLR), .bus (bus0)
  );

  int  n_chk = 0;
  int  n_err = 0;
  op_t q1[$];
  op_t q0[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t rand_op();
    op_t         o;
    logic [31:0] r;
    r       = $urandom;
    o.ctrl  = r[CW-1:0];
    r       = $urandom;
    o.flags = r[FLAGS_W-1:0];
    o.rd1   = $urandom;
    o.rd2   = $urandom;
    o.imm   = $urandom;
    return o;
  endfunction

  function automatic op_t out_of(input bit sel);
    op_t o;
    if (sel) o = {bus1.CtrlE, bus1.FlagsE, bus1.RE1, bus1.RE2, bus1.ExtImmE};
    else     o = {bus0.CtrlE, bus0.FlagsE, bus0.RE1, bus0.RE2, bus0.ExtImmE};
    return o;
  endfunction

  task automatic put1(input bit v, input op_t o, input bit re);
    bus1.ValidD  = v;
    bus1.CtrlD   = o.ctrl;
    bus1.FlagsD  = o.flags;
    bus1.RD1     = o.rd1;
    bus1.RD2     = o.rd2;
    bus1.ExtImmD = o.imm;
    bus1.ReadyE  = re;
  endtask

  task automatic put0(input bit v, input op_t o, input bit re);
    bus0.ValidD  = v;
    bus0.CtrlD   = o.ctrl;
    bus0.FlagsD  = o.flags;
    bus0.RD1     = o.rd1;
    bus0.RD2     = o.rd2;
    bus0.ExtImmD = o.imm;
    bus0.ReadyE  = re;
  endtask

  task automatic put(input bit v, input op_t o, input bit re);
    put1(v, o, re);
    put0(v, o, re);
  endtask

  task automatic check_side(input string pfx, input int n, input op_t head, input bit exp_rdy,
                            input bit v, input bit r, input op_t got);
    logic [4:0] se;
    chk({pfx, " ValidE"}, 128'(v), 128'(n > 0));
    chk({pfx, " ReadyD"}, 128'(r), 128'(exp_rdy));
    if (n > 0) begin
      chk({pfx, " payload"}, 128'(got), 128'(head));
    end else begin
      se = {got.ctrl.PCSrc, got.ctrl.RegWrite, got.ctrl.MemWrite, got.ctrl.Branch, got.ctrl.FlagWrite};
      chk({pfx, " bubble"}, 128'(se), 128'(0));
    end
  endtask

  // Called just after a falling edge with inputs driven; checks outputs against
  // the queue models, then advances the models across the next rising edge.
  task automatic cycle();
    op_t h1, h0, in1, in0;
    bit  rdy1, rdy0, a1, a0, c1, c0, clr;
    #1;
    h1   = (q1.size() > 0) ? q1[0] : '0;
    h0   = (q0.size() > 0) ? q0[0] : '0;
    rdy1 = q1.size() < 2;
    rdy0 = (q0.size() == 0) || bus0.ReadyE;
    check_side("skid", q1.size(), h1, rdy1, bus1.ValidE, bus1.ReadyD, out_of(1'b1));
    check_side("flat", q0.size(), h0, rdy0, bus0.ValidE, bus0.ReadyD, out_of(1'b0));
    a1  = bus1.ValidD && rdy1;
    a0  = bus0.ValidD && rdy0;
    c1  = (q1.size() > 0) && bus1.ReadyE;
    c0  = (q0.size() > 0) && bus0.ReadyE;
    in1 = {bus1.CtrlD, bus1.FlagsD, bus1.RD1, bus1.RD2, bus1.ExtImmD};
    in0 = {bus0.CtrlD, bus0.FlagsD, bus0.RD1, bus0.RD2, bus0.ExtImmD};
    clr = CLR;
    @(posedge CLK);
    if (clr) begin
      q1.delete();
      q0.delete();
    end else begin
      if (c1) void'(q1.pop_front());
      if (a1) q1.push_back(in1);
      if (c0) void'(q0.pop_front());
      if (a0) q0.push_back(in0);
    end
    @(negedge CLK);
  endtask

  op_t o;

  initial begin
    o = '0;
    put(1'b0, o, 1'b0);

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("rst ValidE skid", 128'(bus1.ValidE), 128'(0));
    chk("rst ReadyD skid", 128'(bus1.ReadyD), 128'(1));
    chk("rst ValidE flat", 128'(bus0.ValidE), 128'(0));
    chk("rst ReadyD flat", 128'(bus0.ReadyD), 128'(1));
    chk("rst RE1 skid",    128'(bus1.RE1),    128'(0));
    @(negedge CLK);
    RST = 1'b0;

    // Pass-through then 10 back-to-back ops
    o = rand_op();
    o.rd1 = 32'h1234_5678;
    put(1'b1, o, 1'b1);
    cycle();
    chk("pass ValidE", 128'(bus1.ValidE), 128'(1));
    chk("pass RE1",    128'(bus1.RE1),    128'(32'h1234_5678));
    for (int i = 0; i < 10; i++) begin
      o = rand_op();
      o.rd1 = 32'(i + 100);
      put(1'b1, o, 1'b1);
      cycle();
      chk("b2b RE1", 128'(bus1.RE1), 128'(i + 100));
    end
    put(1'b0, o, 1'b1);
    cycle();
    cycle();

    // Stall and skid: A then B with ReadyE low
    o = rand_op(); o.rd1 = 32'hA;
    put(1'b1, o, 1'b0);
    cycle();
    o = rand_op(); o.rd1 = 32'hB;
    put(1'b1, o, 1'b0);
    cycle();
    put(1'b0, o, 1'b0);
    cycle();
    chk("stall ReadyD", 128'(bus1.ReadyD), 128'(0));
    chk("stall RE1",    128'(bus1.RE1),    128'(32'hA));
    put(1'b0, o, 1'b1);
    cycle();
    chk("drain RE1 B", 128'(bus1.RE1), 128'(32'hB));
    cycle();
    cycle();

    // Flush while full, with a same-edge op C
    o = rand_op();
    put(1'b1, o, 1'b0);
    cycle();
    o = rand_op();
    put(1'b1, o, 1'b0);
    cycle();
    o = rand_op(); o.rd1 = 32'hC;
    put(1'b1, o, 1'b0);
    CLR = 1'b1;
    cycle();
    CLR = 1'b0;
    chk("flush ValidE", 128'(bus1.ValidE), 128'(0));
    chk("flush ReadyD", 128'(bus1.ReadyD), 128'(1));
    put(1'b0, o, 1'b1);
    cycle();
    cycle();

    // Bubble gating after an op with RegWrite and MemWrite set
    o = rand_op();
    o.ctrl.RegWrite = 1'b1;
    o.ctrl.MemWrite = 1'b1;
    put(1'b1, o, 1'b1);
    cycle();
    put(1'b0, o, 1'b1);
    cycle();
    chk("bubble RegWrite", 128'(bus1.CtrlE.RegWrite), 128'(0));
    chk("bubble MemWrite", 128'(bus1.CtrlE.MemWrite), 128'(0));
    cycle();

    // Flat variant: ReadyD follows ReadyE in the same cycle
    o = rand_op();
    put(1'b1, o, 1'b0);
    cycle();
    put(1'b1, o, 1'b0);
    #1;
    chk("flat ReadyD low",  128'(bus0.ReadyD), 128'(0));
    bus0.ReadyE = 1'b1;
    #1;
    chk("flat ReadyD high", 128'(bus0.ReadyD), 128'(1));
    bus0.ReadyE = 1'b0;
    put(1'b0, o, 1'b0);
    cycle();

    // Asynchronous reset mid-cycle with ops held
    #2;
    RST = 1'b1;
    #1;
    chk("arst ValidE skid", 128'(bus1.ValidE), 128'(0));
    chk("arst ReadyD skid", 128'(bus1.ReadyD), 128'(1));
    chk("arst RE1 skid",    128'(bus1.RE1),    128'(0));
    chk("arst ValidE flat", 128'(bus0.ValidE), 128'(0));
    q1.delete();
    q0.delete();
    @(negedge CLK);
    RST = 1'b0;

    // Random traffic against the queue models
    for (int i = 0; i < 1000; i++) begin
      put1($urandom_range(0, 3) != 0, rand_op(), $urandom_range(0, 2) != 0);
      put0($urandom_range(0, 3) != 0, rand_op(), $urandom_range(0, 2) != 0);
      CLR = ($urandom_range(0, 49) == 0);
      cycle();
    end
    CLR = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
